// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//   Shared definitions for the gated frequency counter:
//   - state_t       : FSM states IDLE / GATE / DONE
//   - DEF_GATE_CYCLES, DEF_CNT_W : default parameter values
//   - gate_cnt_w()  : width of the gate-window counter for a given window
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_GATE_CYCLES = 50_000_000;
  localparam int DEF_CNT_W       = 32;

  // The counter only has to reach GATE_CYCLES-1, so $clog2 bits suffice;
  // clamp to one bit so a degenerate window still yields a legal vector.
  function automatic int gate_cnt_w(input int cycles);
    if (cycles > 2) begin
      return $clog2(cycles);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if
//   Bundles the measurement request/result signals of freq_meter.
//   sig_in : signal under measurement (asynchronous to clk)
//   start  : one-shot measurement request
//   cont   : continuous re-arm after every result
//   busy   : gate window open
//   valid  : one-cycle pulse when freq/ovf are updated
//   freq   : edge count of the last completed window
//   ovf    : last window's count saturated
//   master : the side that requests measurements (drives sig_in/start/cont)
//   slave  : the meter itself
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             sig_in;
  logic             start;
  logic             cont;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] freq;
  logic             ovf;

  modport master (
    output sig_in, start, cont,
    input  busy, valid, freq, ovf
  );

  modport slave (
    input  sig_in, start, cont,
    output busy, valid, freq, ovf
  );

endinterface

// File: rtl/freq_meter_sync_edge.sv
// sync_edge
//   Brings an asynchronous signal into the clk domain and produces a
//   registered one-cycle pulse for each rising edge.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   sig_in : asynchronous input
//   rise   : one-cycle pulse per detected rising edge
module sync_edge
  import freq_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic hist_r;
  logic primed_r;
  logic rise_r;

  // Synchronizer chain, history flop, primed bit and registered edge pulse.
  // On the single unprimed cycle after reset the whole chain is preloaded
  // with the current input level, so a signal already high at reset release
  // looks like a steady level rather than a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      hist_r   <= 1'b0;
      primed_r <= 1'b0;
      rise_r   <= 1'b0;
    end else begin
      primed_r <= 1'b1;
      sync1_r  <= sig_in;
      if (primed_r) begin
        sync2_r <= sync1_r;
        hist_r  <= sync2_r;
      end else begin
        sync2_r <= sig_in;
        hist_r  <= sig_in;
      end
      rise_r <= sync2_r & ~hist_r & primed_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//   Gated frequency counter: counts rising edges of bus.sig_in over a window
//   of GATE_CYCLES clk cycles and reports the count.
//   Parameters : GATE_CYCLES (window length, >= 2), CNT_W (count width)
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   bus        : freq_meter_if.slave (sig_in, start, cont -> busy, valid,
//                freq, ovf)
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  freq_meter_if.slave bus
);

  localparam int               GW        = gate_cnt_w(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [GW-1:0]    gate_cnt_r;
  logic [CNT_W-1:0] edge_cnt_r;
  logic [CNT_W-1:0] edge_cnt_nxt_s;
  logic             ovf_flag_r;
  logic             ovf_flag_nxt_s;
  logic             rise_s;
  logic             busy_r;
  logic             valid_r;
  logic [CNT_W-1:0] freq_r;
  logic             ovf_r;

  sync_edge u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (bus.sig_in),
    .rise   (rise_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; start/cont are only looked at in IDLE and DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start || bus.cont) begin
          state_nxt_s = GATE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GATE: begin
        if (gate_cnt_r == GATE_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = GATE;
        end
      end
      DONE: begin
        if (bus.cont) begin
          state_nxt_s = GATE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Gate counter: counts only while staying in GATE, so it is zero on every
  // window entry and is cleared on the last cycle instead of reaching
  // GATE_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt_r <= {GW{1'b0}};
    end else if ((state_r == GATE) && (state_nxt_s == GATE)) begin
      gate_cnt_r <= gate_cnt_r + GW'(1);
    end else begin
      gate_cnt_r <= {GW{1'b0}};
    end
  end

  // Saturating edge counter next value; outside GATE it is held at zero so
  // edges in DONE/IDLE are dropped and each window starts from zero.
  always_comb begin
    edge_cnt_nxt_s = edge_cnt_r;
    ovf_flag_nxt_s = ovf_flag_r;
    if (state_r == GATE) begin
      if (rise_s) begin
        if (edge_cnt_r == CNT_MAX) begin
          ovf_flag_nxt_s = 1'b1;
        end else begin
          edge_cnt_nxt_s = edge_cnt_r + CNT_W'(1);
        end
      end else begin
        edge_cnt_nxt_s = edge_cnt_r;
      end
    end else begin
      edge_cnt_nxt_s = {CNT_W{1'b0}};
      ovf_flag_nxt_s = 1'b0;
    end
  end

  // Edge counter and overflow flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_r <= {CNT_W{1'b0}};
      ovf_flag_r <= 1'b0;
    end else begin
      edge_cnt_r <= edge_cnt_nxt_s;
      ovf_flag_r <= ovf_flag_nxt_s;
    end
  end

  // Output registers. They are loaded from the next-state/next-count values
  // so busy, valid and the result line up with the DONE cycle itself, and
  // the edge seen on the last gate cycle is still included in the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      freq_r  <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      busy_r  <= (state_nxt_s == GATE);
      valid_r <= (state_nxt_s == DONE);
      if (state_nxt_s == DONE) begin
        freq_r <= edge_cnt_nxt_s;
        ovf_r  <= ovf_flag_nxt_s;
      end
    end
  end

  assign bus.busy  = busy_r;
  assign bus.valid = valid_r;
  assign bus.freq  = freq_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
//   Self-checking bench for freq_meter: two instances (CNT_W=32 and CNT_W=4,
//   both with a 100-cycle window), table-driven single windows, randomized
//   windows checked against an edge-counting reference, and hand-written
//   sequences for restart, reset, primed and continuous-mode behaviour.
module tb_freq_meter;

  localparam int G = 100;

  typedef struct {
    int sel;
    int per;
    int hi;
    int exp_f;
    int exp_o;
    int tol;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  // Stimulus generator state for sig_in (per 0: low, per <0: high).
  int   per_s  = 0;
  int   hi_s   = 0;
  int   ph_s   = 0;
  logic last_s = 1'b0;

  // Outputs sampled at the latest negedge, and whether sig_in just rose.
  logic s_busy;
  logic s_valid;
  logic s_ovf;
  int   s_freq;
  logic rose_s;

  freq_meter_if #(.CNT_W(32)) ifa ();
  freq_meter_if #(.CNT_W(4))  ifb ();

  freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d tol=%0d", name, act, exp, tol);
    end
  endtask

  // One cycle: at the negedge sample the selected DUT, then drive sig_in.
  task automatic sample_drive(input int sel);
    logic v;
    @(negedge clk);
    if (sel == 0) begin
      s_busy = ifa.busy; s_valid = ifa.valid; s_freq = int'(ifa.freq); s_ovf = ifa.ovf;
    end else begin
      s_busy = ifb.busy; s_valid = ifb.valid; s_freq = int'(ifb.freq); s_ovf = ifb.ovf;
    end
    if (per_s == 0) begin
      v = 1'b0;
    end else if (per_s < 0) begin
      v = 1'b1;
    end else begin
      v = (ph_s < hi_s);
      ph_s = (ph_s + 1) % per_s;
    end
    rose_s = v & ~last_s;
    last_s = v;
    if (sel == 0) begin
      ifa.sig_in = v; ifb.sig_in = 1'b0;
    end else begin
      ifb.sig_in = v; ifa.sig_in = 1'b0;
    end
  endtask

  task automatic drive_start(input int sel, input logic v);
    if (sel == 0) ifa.start = v;
    else ifb.start = v;
  endtask

  // One single-shot window. The reference count is the number of sig_in
  // rising edges the bench drove into the G sampling cycles of the window.
  task automatic run_window(input string tag, input int sel, input int per, input int hi,
                            input int restart_k, input int exp_f, input int exp_o,
                            input int tol, input bit use_model);
    int nbusy, nvalid, vpos, vfreq, vovf, model, b1, want;
    nbusy = 0; nvalid = 0; vpos = 0; vfreq = -1; vovf = -1; model = 0; b1 = 0;
    per_s = per; hi_s = hi; ph_s = 0;
    repeat (6) sample_drive(sel);
    sample_drive(sel);
    drive_start(sel, 1'b1);
    for (int k = 1; k <= G + 5; k++) begin
      sample_drive(sel);
      drive_start(sel, (k == restart_k));
      if (k <= G && rose_s) model++;
      if (k == 1) b1 = int'(s_busy);
      if (s_busy) nbusy++;
      if (s_valid) begin
        nvalid++; vpos = k; vfreq = s_freq; vovf = int'(s_ovf);
      end
    end
    want = use_model ? model : exp_f;
    chk({tag, "_busy_first"}, b1, 1, 0);
    chk({tag, "_busy_len"}, nbusy, G, 0);
    chk({tag, "_valid_pos"}, vpos, G + 1, 0);
    chk({tag, "_valid_cnt"}, nvalid, 1, 0);
    chk({tag, "_freq"}, vfreq, want, tol);
    chk({tag, "_ovf"}, vovf, exp_o, 0);
    chk({tag, "_freq_hold"}, s_freq, want, tol);
  endtask

  vec_t tbl[7];

  initial begin
    int nvalid, nbusy, vpos, vfreq, per, hi;
    int vp[4];

    ifa.sig_in = 1'b0; ifa.start = 1'b0; ifa.cont = 1'b0;
    ifb.sig_in = 1'b0; ifb.start = 1'b0; ifb.cont = 1'b0;

    tbl[0] = '{0, 10, 5, 10, 0, 1};
    tbl[1] = '{0,  0, 0,  0, 0, 0};
    tbl[2] = '{1,  4, 2, 15, 1, 0};
    tbl[3] = '{1,  0, 0,  0, 0, 0};
    tbl[4] = '{0,  4, 2, 25, 0, 1};
    tbl[5] = '{1,  8, 4, 12, 0, 1};
    tbl[6] = '{0, 50, 10, 2, 0, 1};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(ifa.busy), 0, 0);
    chk("rst_valid", int'(ifa.valid), 0, 0);
    chk("rst_freq", int'(ifa.freq), 0, 0);
    chk("rst_ovf", int'(ifa.ovf), 0, 0);
    chk("rst_freq_b", int'(ifb.freq), 0, 0);
    rst = 1'b0;

    // Table-driven single windows.
    for (int i = 0; i < 7; i++) begin
      run_window($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].per, tbl[i].hi, -1,
                 tbl[i].exp_f, tbl[i].exp_o, tbl[i].tol, 1'b0);
    end

    // start pulsed 30 cycles into the window is ignored.
    run_window("restart", 0, 10, 5, 31, 10, 0, 1, 1'b0);

    // Randomized windows against the edge-counting reference.
    for (int i = 0; i < 6; i++) begin
      per = int'($urandom_range(60, 4));
      hi  = int'($urandom_range(per - 2, 2));
      run_window($sformatf("rnd_a%0d", i), 0, per, hi, -1, 0, 0, 1, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      per = int'($urandom_range(60, 16));
      hi  = int'($urandom_range(per - 2, 2));
      run_window($sformatf("rnd_b%0d", i), 1, per, hi, -1, 0, 0, 1, 1'b1);
    end

    // Reset 50 cycles into a window: immediate clear, no result afterwards.
    per_s = 10; hi_s = 5; ph_s = 0;
    repeat (6) sample_drive(0);
    sample_drive(0);
    ifa.start = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      sample_drive(0);
      ifa.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(ifa.busy), 0, 0);
    chk("midrst_freq", int'(ifa.freq), 0, 0);
    chk("midrst_valid", int'(ifa.valid), 0, 0);
    repeat (3) sample_drive(0);
    rst = 1'b0;
    nvalid = 0; nbusy = 0;
    for (int k = 0; k < 150; k++) begin
      sample_drive(0);
      if (s_valid) nvalid++;
      if (s_busy) nbusy++;
    end
    chk("midrst_no_valid", nvalid, 0, 0);
    chk("midrst_no_busy", nbusy, 0, 0);

    // sig_in high across reset release, start on the first cycle after it.
    rst = 1'b1;
    per_s = -1;
    repeat (4) sample_drive(0);
    rst = 1'b0;
    ifa.start = 1'b1;
    vpos = 0; vfreq = -1;
    for (int k = 1; k <= G + 5; k++) begin
      sample_drive(0);
      ifa.start = 1'b0;
      if (s_valid) begin
        vpos = k; vfreq = s_freq;
      end
    end
    chk("primed_valid_pos", vpos, G + 1, 0);
    chk("primed_freq", vfreq, 0, 0);

    // Continuous mode; cont dropped during the third window.
    per_s = 20; hi_s = 10; ph_s = 0;
    repeat (6) sample_drive(0);
    sample_drive(0);
    ifa.cont = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 4; i++) vp[i] = 0;
    for (int k = 1; k <= 420; k++) begin
      sample_drive(0);
      if (k == 250) ifa.cont = 1'b0;
      if (s_valid) begin
        if (nvalid < 4) vp[nvalid] = k;
        nvalid++;
        chk("cont_freq", s_freq, 5, 1);
        chk("cont_ovf", int'(s_ovf), 0, 0);
      end
    end
    chk("cont_valid_cnt", nvalid, 3, 0);
    chk("cont_first_pos", vp[0], G + 1, 0);
    chk("cont_spacing1", vp[1] - vp[0], G + 1, 0);
    chk("cont_spacing2", vp[2] - vp[1], G + 1, 0);
    chk("cont_idle_busy", int'(s_busy), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
